// File: rtl/nids_pkg.sv
`default_nettype none
// ============================================================================
// nids_pkg : shared FSM state encoding, result record and counter helper
// Rev 1.0  : initial release
// ============================================================================
package nids_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_FEATURES_DEF = 28;
  localparam int SRC_FIELD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef struct packed {
    logic                   attack;
    logic [31:0]            major;
    logic [31:0]            minor;
    logic                   timeout;
    logic [SRC_FIELD_W-1:0] src;
  } result_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot arbiter, pointer moves past each winner
// Rev 1.0    : initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   idx;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nids_ingress_scheduler.sv
`default_nettype none
// ============================================================================
// nids_ingress_scheduler : arbitrates packet sources into the FEM/PCA pipeline
//                          one packet at a time and returns a tagged result
// Rev 1.0                : initial release
// ============================================================================
module nids_ingress_scheduler
  import nids_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int N_FEATURES = N_FEATURES_DEF,
  parameter  int N_SRC      = 4,
  parameter  int TIMEOUT    = 1024,
  localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         enable,
  input  logic [N_SRC-1:0]                             src_req,
  input  logic [N_SRC-1:0][N_FEATURES-1:0][DATA_WIDTH-1:0] src_features,
  output logic [N_SRC-1:0]                             src_gnt,
  output logic [N_FEATURES-1:0][DATA_WIDTH-1:0]        pipe_features,
  output logic                                         pipe_valid,
  input  logic                                         pipe_valid_out,
  input  logic                                         pipe_attack,
  input  logic [31:0]                                  pipe_major,
  input  logic [31:0]                                  pipe_minor,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [SRC_W-1:0]                             res_src,
  output logic                                         res_attack,
  output logic [31:0]                                  res_major,
  output logic [31:0]                                  res_minor,
  output logic                                         res_timeout,
  output logic [31:0]                                  stat_pkts,
  output logic [31:0]                                  stat_attacks,
  output logic [31:0]                                  stat_timeouts
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                               state_q;
  logic [N_SRC-1:0]                     gnt_q, arb_gnt;
  logic [N_FEATURES-1:0][DATA_WIDTH-1:0] feat_q;
  logic                                 pvalid_q, rvalid_q;
  result_t                              res_q;
  logic [SRC_W-1:0]                     src_q, gnt_idx;
  logic [TW-1:0]                        timer_q;
  logic [31:0]                          pkts_q, atk_q, to_q;
  logic                                 grant_now;
  logic                                 unused_src_bits;

  assign grant_now = (state_q == ST_IDLE) && enable && (|src_req);

  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (src_req),
    .advance (grant_now),
    .gnt     (arb_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (arb_gnt[i]) gnt_idx = SRC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      feat_q   <= '0;
      pvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      res_q    <= '0;
      src_q    <= '0;
      timer_q  <= '0;
      pkts_q   <= '0;
      atk_q    <= '0;
      to_q     <= '0;
    end else begin
      gnt_q    <= '0;
      pvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            gnt_q   <= arb_gnt;
            feat_q  <= src_features[gnt_idx];
            src_q   <= gnt_idx;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pvalid_q <= 1'b1;
          timer_q  <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle still counts as valid.
          if (pipe_valid_out) begin
            res_q    <= '{attack: pipe_attack, major: pipe_major, minor: pipe_minor,
                          timeout: 1'b0, src: SRC_FIELD_W'(src_q)};
            rvalid_q <= 1'b1;
            state_q  <= ST_REPORT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            res_q    <= '{attack: 1'b0, major: 32'd0, minor: 32'd0,
                          timeout: 1'b1, src: SRC_FIELD_W'(src_q)};
            rvalid_q <= 1'b1;
            state_q  <= ST_REPORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            rvalid_q <= 1'b0;
            pkts_q   <= sat_inc(pkts_q);
            if (res_q.attack)  atk_q <= sat_inc(atk_q);
            if (res_q.timeout) to_q  <= sat_inc(to_q);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_gnt         = gnt_q;
  assign pipe_features   = feat_q;
  assign pipe_valid      = pvalid_q;
  assign res_valid       = rvalid_q;
  assign res_src         = res_q.src[SRC_W-1:0];
  assign res_attack      = res_q.attack;
  assign res_major       = res_q.major;
  assign res_minor       = res_q.minor;
  assign res_timeout     = res_q.timeout;
  assign stat_pkts       = pkts_q;
  assign stat_attacks    = atk_q;
  assign stat_timeouts   = to_q;
  assign unused_src_bits = ^res_q.src;

endmodule
`default_nettype wire

// File: doc/nids_ingress_scheduler.md
NIDS_INGRESS_SCHEDULER -- requirements
Module: nids_ingress_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one feature word.
REQ-002 SHALL have parameter N_FEATURES, default 28: features per packet vector.
REQ-003 SHALL have parameter N_SRC, default 4: number of packet requesters.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum WAIT cycles for a pipeline result.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock; rst_n  in  1  async reset, active low.
REQ-006 SHALL have port enable  in  1: when low, no new grants are issued.
REQ-007 SHALL have port src_req  in  N_SRC: per-source request, held until granted.
REQ-008 SHALL have port src_features  in  N_SRC x N_FEATURES x DATA_WIDTH: per-source feature vectors, stable while src_req is high.
REQ-009 SHALL have port src_gnt  out  N_SRC: one-hot, single-cycle grant.
REQ-010 SHALL have port pipe_features  out  N_FEATURES x DATA_WIDTH: registered vector to the FEM/PCA pipeline.
REQ-011 SHALL have port pipe_valid  out  1: one-cycle issue strobe to the pipeline.
REQ-012 SHALL have ports pipe_valid_out  in  1, pipe_attack  in  1, pipe_major  in  32 and pipe_minor  in  32: the pipeline result.
REQ-013 SHALL have ports res_valid  out  1, res_ready  in  1, res_src  out  clog2(N_SRC), res_attack  out  1, res_major  out  32, res_minor  out  32 and res_timeout  out  1: the tagged result.
REQ-014 SHALL have ports stat_pkts  out  32, stat_attacks  out  32 and stat_timeouts  out  32: statistics counters.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, REPORT.
REQ-016 In IDLE, with enable=1 and any src_req high, SHALL assert src_gnt for exactly one source (round-robin, starting after the last granted source), capture its features into pipe_features, and go to ISSUE.
REQ-017 The round-robin pointer SHALL start at source 0 after reset, so source 0 has the highest priority for the first grant.
REQ-018 In ISSUE, SHALL assert pipe_valid for one cycle and go to WAIT; the grant is in cycle T and pipe_valid is in cycle T+1.
REQ-019 In WAIT, SHALL capture pipe_attack, pipe_major and pipe_minor on pipe_valid_out, clear res_timeout, and go to REPORT.
REQ-020 In WAIT, when TIMEOUT cycles elapse without pipe_valid_out, SHALL set res_timeout=1, res_attack=0 and scores=0, then go to REPORT.
REQ-021 If pipe_valid_out and timer expiry coincide, SHALL treat the result as valid (no timeout).
REQ-022 SHALL ignore pipe_valid_out outside WAIT.
REQ-023 In REPORT, SHALL hold res_valid and all res_* outputs stable until res_ready=1, then return to IDLE in the next cycle.
REQ-024 SHALL keep at most one packet outstanding; src_gnt SHALL be 0 outside IDLE.
REQ-025 On every REPORT handshake, SHALL increment stat_pkts; SHALL increment stat_attacks if res_attack=1, and stat_timeouts if res_timeout=1.
REQ-026 All counters SHALL saturate at 0xFFFFFFFF.
REQ-027 Deasserting enable SHALL only block new grants; an in-flight packet completes normally.

Reset
REQ-028 While rst_n=0, SHALL hold the state at IDLE, the rr pointer at 0, and all outputs at 0 (including pipe_features, res_* and stat_*).
REQ-029 Reset asserted mid-operation SHALL abort the packet immediately with no result reported; after release, a late pipe_valid_out SHALL be ignored.

Structure
REQ-030 SHALL place the FSM state enum and the result struct (attack, major, minor, timeout, src) in a shared package nids_pkg, alongside the DATA_WIDTH and N_FEATURES defaults.
REQ-031 SHALL implement the round-robin grant in one sub-module rr_arbiter (inputs req, advance; output one-hot gnt).

Verification
REQ-032 Reset, then src_req=4'b0001 -> src_gnt=0001 at T, pipe_valid at T+1; pipe_valid_out at T+5 with attack=1, major=0x100 -> res_valid with res_src=0, res_major=0x100; after res_ready, stat_pkts=1 and stat_attacks=1.
REQ-033 src_req=4'b1111 held for 8 packets -> grant order 0,1,2,3,0,1,2,3, with no grant while busy.
REQ-034 Pipeline silent for TIMEOUT=16 -> res_timeout=1 at WAIT cycle 16; stat_timeouts=1; res_attack=0.
REQ-035 res_ready held low for 10 cycles in REPORT -> res_* stable, no new src_gnt; stray pipe_valid_out ignored.
REQ-036 rst_n pulsed low during WAIT -> outputs zero asynchronously; a later pipe_valid_out produces no res_valid.
REQ-037 enable=0 with src_req=4'b0010 -> no grant; enable=1 -> grant to source 1 in the next cycle.
